// File: rtl/yadmc_wbuf.sv
// rtl/yadmc_wbuf.sv - posted-write buffer in front of the YADMC Wishbone slave
// Writes are acked once queued; reads wait until every queued write has drained.
module yadmc_wbuf #(
  parameter int fifo_depth = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [31:0]           s_wb_adr_i,
  input  logic [31:0]           s_wb_dat_i,
  output logic [31:0]           s_wb_dat_o,
  input  logic [3:0]            s_wb_sel_i,
  input  logic                  s_wb_cyc_i,
  input  logic                  s_wb_stb_i,
  input  logic                  s_wb_we_i,
  output logic                  s_wb_ack_o,
  output logic [31:0]           m_wb_adr_o,
  output logic [31:0]           m_wb_dat_o,
  input  logic [31:0]           m_wb_dat_i,
  output logic [3:0]            m_wb_sel_o,
  output logic                  m_wb_cyc_o,
  output logic                  m_wb_stb_o,
  output logic                  m_wb_we_o,
  input  logic                  m_wb_ack_i,
  output logic [fifo_depth:0]   wbuf_level,
  output logic                  wbuf_empty
);

  localparam int ENTRIES = 1 << fifo_depth;
  localparam logic [fifo_depth:0]   FULL_LEVEL = (fifo_depth + 1)'(ENTRIES);
  localparam logic [fifo_depth:0]   LVL_ONE    = (fifo_depth + 1)'(1);
  localparam logic [fifo_depth-1:0] PTR_ONE    = fifo_depth'(1);

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_WRITE = 2'd1;
  localparam logic [1:0] M_READ  = 2'd2;
  localparam logic [1:0] M_GAP   = 2'd3;

  logic [29:0] fifo_adr_q [ENTRIES];
  logic [31:0] fifo_dat_q [ENTRIES];
  logic [3:0]  fifo_sel_q [ENTRIES];

  logic [fifo_depth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [fifo_depth:0]   level_q, level_d;
  logic [1:0]            state_q, state_d;
  logic                  s_ack_q, s_ack_d;
  logic [31:0]           s_dat_q, s_dat_d;
  logic                  m_cyc_q, m_cyc_d, m_we_q, m_we_d;
  logic [31:0]           m_adr_q, m_adr_d, m_dat_q, m_dat_d;
  logic [3:0]            m_sel_q, m_sel_d;
  logic                  empty_q, empty_d;
  logic                  rd_drop_q, rd_drop_d;

  logic s_new, fifo_full, push, pop, rd_deliver;
  logic unused_adr_bits;

  assign unused_adr_bits = ^s_wb_adr_i[1:0];

  // The ack cycle itself never counts as a fresh request, so a held strobe is not pushed twice.
  assign s_new      = s_wb_cyc_i & s_wb_stb_i & ~s_ack_q;
  assign fifo_full  = (level_q == FULL_LEVEL);
  assign pop        = (state_q == M_WRITE) & m_wb_ack_i;
  assign push       = s_new & s_wb_we_i & (~fifo_full | pop);
  assign rd_deliver = (state_q == M_READ) & m_wb_ack_i & ~rd_drop_q & s_wb_cyc_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_cyc_d = m_cyc_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    m_sel_d = m_sel_q;
    case (state_q)
      M_IDLE: begin
        // Queued writes always go first so a read never overtakes them.
        if (level_q != '0) begin
          state_d = M_WRITE;
          m_cyc_d = 1'b1;
          m_we_d  = 1'b1;
          m_adr_d = {fifo_adr_q[rd_ptr_q], 2'b00};
          m_dat_d = fifo_dat_q[rd_ptr_q];
          m_sel_d = fifo_sel_q[rd_ptr_q];
        end else if (s_new & ~s_wb_we_i) begin
          state_d = M_READ;
          m_cyc_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = {s_wb_adr_i[31:2], 2'b00};
          m_sel_d = s_wb_sel_i;
        end
      end
      M_WRITE, M_READ: begin
        if (m_wb_ack_i) begin
          state_d = M_GAP;
          m_cyc_d = 1'b0;
          m_we_d  = 1'b0;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    s_ack_d   = push | rd_deliver;
    s_dat_d   = rd_deliver ? m_wb_dat_i : s_dat_q;
    rd_drop_d = (state_q == M_READ) & ~m_wb_ack_i & (rd_drop_q | ~s_wb_cyc_i);
    empty_d   = (level_d == '0) & (state_d == M_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_adr_q[wr_ptr_q] <= s_wb_adr_i[31:2];
      fifo_dat_q[wr_ptr_q] <= s_wb_dat_i;
      fifo_sel_q[wr_ptr_q] <= s_wb_sel_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= M_IDLE;
      s_ack_q   <= 1'b0;
      s_dat_q   <= '0;
      m_cyc_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      m_sel_q   <= '0;
      empty_q   <= 1'b1;
      rd_drop_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      s_ack_q   <= s_ack_d;
      s_dat_q   <= s_dat_d;
      m_cyc_q   <= m_cyc_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      m_sel_q   <= m_sel_d;
      empty_q   <= empty_d;
      rd_drop_q <= rd_drop_d;
    end
  end

  assign s_wb_ack_o = s_ack_q;
  assign s_wb_dat_o = s_dat_q;
  assign m_wb_cyc_o = m_cyc_q;
  assign m_wb_stb_o = m_cyc_q;
  assign m_wb_we_o  = m_we_q;
  assign m_wb_adr_o = m_adr_q;
  assign m_wb_dat_o = m_dat_q;
  assign m_wb_sel_o = m_sel_q;
  assign wbuf_level = level_q;
  assign wbuf_empty = empty_q;

endmodule

// File: tb/tb_yadmc_wbuf.sv
// tb/tb_yadmc_wbuf.sv - directed bench for the yadmc_wbuf posted-write buffer
module tb_yadmc_wbuf;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] s_wb_adr_i, s_wb_dat_i, s_wb_dat_o;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_cyc_i, s_wb_stb_i, s_wb_we_i, s_wb_ack_o;
  logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_ack_i;
  logic [2:0]  wbuf_level;
  logic        wbuf_empty;

  logic        man_ack = 1'b0;
  logic        auto_ack = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          s_ack_cnt = 0;
  int          rd_cnt = 0;
  int          rd_level = 7;
  logic [32:0] log_q [$];

  yadmc_wbuf #(.fifo_depth(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .s_wb_adr_i (s_wb_adr_i),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_sel_i (s_wb_sel_i),
    .s_wb_cyc_i (s_wb_cyc_i),
    .s_wb_stb_i (s_wb_stb_i),
    .s_wb_we_i  (s_wb_we_i),
    .s_wb_ack_o (s_wb_ack_o),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_sel_o (m_wb_sel_o),
    .m_wb_cyc_o (m_wb_cyc_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_ack_i (m_wb_ack_i),
    .wbuf_level (wbuf_level),
    .wbuf_empty (wbuf_empty)
  );

  always #5 sys_clk = ~sys_clk;

  // YADMC stand-in: manual ack or zero-wait combinational ack
  assign m_wb_ack_i = man_ack | (auto_ack & m_wb_cyc_o & m_wb_stb_o);

  always @(posedge sys_clk) begin
    if (m_wb_cyc_o && m_wb_stb_o && m_wb_ack_i) begin
      log_q.push_back({m_wb_we_o, m_wb_adr_o});
      if (!m_wb_we_o) begin
        rd_cnt++;
        rd_level = 32'(wbuf_level);
      end
    end
    if (s_wb_ack_o) s_ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    s_wb_cyc_i = 1'b1;
    s_wb_stb_i = 1'b1;
    s_wb_we_i  = we;
    s_wb_adr_i = adr;
    s_wb_dat_i = dat;
    s_wb_sel_i = 4'hF;
  endtask

  task automatic idle_bus();
    s_wb_cyc_i = 1'b0;
    s_wb_stb_i = 1'b0;
    s_wb_we_i  = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int max);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!s_wb_ack_o && n < max);
    chk(tag, 32'(s_wb_ack_o), 32'd1);
  endtask

  task automatic wait_empty(input string tag, input int max);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!wbuf_empty && n < max);
    chk(tag, 32'(wbuf_empty), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ack"}, 32'(s_wb_ack_o), 32'd0);
    chk({tag, "_s_dat"}, s_wb_dat_o, 32'd0);
    chk({tag, "_m_cyc"}, 32'(m_wb_cyc_o), 32'd0);
    chk({tag, "_m_stb"}, 32'(m_wb_stb_o), 32'd0);
    chk({tag, "_m_we"}, 32'(m_wb_we_o), 32'd0);
    chk({tag, "_m_adr"}, m_wb_adr_o, 32'd0);
    chk({tag, "_m_dat"}, m_wb_dat_o, 32'd0);
    chk({tag, "_m_sel"}, 32'(m_wb_sel_o), 32'd0);
    chk({tag, "_level"}, 32'(wbuf_level), 32'd0);
    chk({tag, "_empty"}, 32'(wbuf_empty), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n  = 1'b0;
    idle_bus();
    s_wb_adr_i = '0;
    s_wb_dat_i = '0;
    s_wb_sel_i = '0;
    m_wb_dat_i = '0;
    tick(2);
    chk_reset_outputs("rst");
    sys_rst_n = 1'b1;

    // single write, master cycle, one-cycle gap
    req(1'b1, 32'h100, 32'hDEAD_BEEF);
    tick(1);
    chk("t1_ack", 32'(s_wb_ack_o), 32'd1);
    chk("t1_level", 32'(wbuf_level), 32'd1);
    chk("t1_cyc_early", 32'(m_wb_cyc_o), 32'd0);
    idle_bus();
    tick(1);
    chk("t1_ack_pulse", 32'(s_wb_ack_o), 32'd0);
    chk("t1_m_cyc", 32'(m_wb_cyc_o), 32'd1);
    chk("t1_m_we", 32'(m_wb_we_o), 32'd1);
    chk("t1_m_adr", m_wb_adr_o, 32'h100);
    chk("t1_m_dat", m_wb_dat_o, 32'hDEAD_BEEF);
    chk("t1_m_sel", 32'(m_wb_sel_o), 32'hF);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    chk("t1_gap_cyc", 32'(m_wb_cyc_o), 32'd0);
    chk("t1_gap_level", 32'(wbuf_level), 32'd0);
    chk("t1_gap_empty", 32'(wbuf_empty), 32'd0);
    tick(1);
    chk("t1_empty", 32'(wbuf_empty), 32'd1);
    chk("t1_idle_cyc", 32'(m_wb_cyc_o), 32'd0);

    // fill the FIFO, fifth write stalls until one pop
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 32'(32'h300 + 4 * i), 32'(32'h1111_0000 + i));
      tick(1);
      chk("t2_ack", 32'(s_wb_ack_o), 32'd1);
      chk("t2_level", 32'(wbuf_level), 32'(i + 1));
      tick(1);
    end
    req(1'b1, 32'h310, 32'h1111_0004);
    tick(1);
    chk("t2_stall_ack", 32'(s_wb_ack_o), 32'd0);
    chk("t2_full_level", 32'(wbuf_level), 32'd4);
    tick(2);
    chk("t2_stall_ack2", 32'(s_wb_ack_o), 32'd0);
    chk("t2_head_adr", m_wb_adr_o, 32'h300);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    chk("t2_ack5", 32'(s_wb_ack_o), 32'd1);
    chk("t2_level_kept", 32'(wbuf_level), 32'd4);
    idle_bus();
    auto_ack = 1'b1;
    wait_empty("t2_drain", 40);
    chk("t2_log_n", 32'(log_q.size()), 32'd5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t2_order", log_q[i][31:0], 32'(32'h300 + 4 * i));
    end

    // read after two writes must follow them on the master side
    log_q.delete();
    rd_level = 7;
    m_wb_dat_i = 32'hCAFE_0200;
    req(1'b1, 32'h200, 32'hA0A0_0200);
    tick(1);
    chk("t3_ack_w0", 32'(s_wb_ack_o), 32'd1);
    req(1'b1, 32'h204, 32'hA0A0_0204);
    wait_ack("t3_ack_w1", 4);
    req(1'b0, 32'h200, 32'h0);
    wait_ack("t3_ack_r", 30);
    chk("t3_rdata", s_wb_dat_o, 32'hCAFE_0200);
    idle_bus();
    tick(1);
    chk("t3_ack_pulse", 32'(s_wb_ack_o), 32'd0);
    chk("t3_rd_level", 32'(rd_level), 32'd0);
    chk("t3_log_n", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t3_o0_we", 32'(log_q[0][32]), 32'd1);
      chk("t3_o0_adr", log_q[0][31:0], 32'h200);
      chk("t3_o1_we", 32'(log_q[1][32]), 32'd1);
      chk("t3_o1_adr", log_q[1][31:0], 32'h204);
      chk("t3_o2_we", 32'(log_q[2][32]), 32'd0);
      chk("t3_o2_adr", log_q[2][31:0], 32'h200);
    end

    // strobe held through the ack cycle is not pushed twice
    auto_ack = 1'b0;
    req(1'b1, 32'h400, 32'h4444_0000);
    tick(1);
    chk("t4_ack_a", 32'(s_wb_ack_o), 32'd1);
    chk("t4_lvl_a", 32'(wbuf_level), 32'd1);
    tick(1);
    chk("t4_ack_hold_a", 32'(s_wb_ack_o), 32'd0);
    chk("t4_lvl_hold_a", 32'(wbuf_level), 32'd1);
    req(1'b1, 32'h404, 32'h4444_0004);
    tick(1);
    chk("t4_ack_b", 32'(s_wb_ack_o), 32'd1);
    chk("t4_lvl_b", 32'(wbuf_level), 32'd2);
    tick(1);
    chk("t4_ack_hold_b", 32'(s_wb_ack_o), 32'd0);
    chk("t4_lvl_hold_b", 32'(wbuf_level), 32'd2);
    idle_bus();
    auto_ack = 1'b1;
    wait_empty("t4_drain", 30);

    // read abandoned while writes are still queued
    auto_ack = 1'b0;
    log_q.delete();
    rd_cnt = 0;
    req(1'b1, 32'h500, 32'h5555_0000);
    tick(1);
    chk("t5_ack_w0", 32'(s_wb_ack_o), 32'd1);
    req(1'b1, 32'h504, 32'h5555_0004);
    wait_ack("t5_ack_w1", 4);
    req(1'b0, 32'h508, 32'h0);
    tick(3);
    chk("t5_rd_wait", 32'(s_wb_ack_o), 32'd0);
    chk("t5_level", 32'(wbuf_level), 32'd2);
    idle_bus();
    s_ack_cnt = 0;
    auto_ack = 1'b1;
    wait_empty("t5_drain", 30);
    tick(4);
    chk("t5_no_ack", 32'(s_ack_cnt), 32'd0);
    chk("t5_no_read", 32'(rd_cnt), 32'd0);
    chk("t5_log_n", 32'(log_q.size()), 32'd2);

    // asynchronous reset in the middle of a master write
    auto_ack = 1'b0;
    req(1'b1, 32'h600, 32'h6666_0000);
    tick(1);
    chk("t6_ack_w0", 32'(s_wb_ack_o), 32'd1);
    req(1'b1, 32'h604, 32'h6666_0004);
    wait_ack("t6_ack_w1", 4);
    req(1'b1, 32'h608, 32'h6666_0008);
    wait_ack("t6_ack_w2", 4);
    chk("t6_level", 32'(wbuf_level), 32'd3);
    chk("t6_m_cyc", 32'(m_wb_cyc_o), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    idle_bus();
    tick(2);
    sys_rst_n = 1'b1;
    log_q.delete();
    tick(5);
    chk("t6_post_cyc", 32'(m_wb_cyc_o), 32'd0);
    chk("t6_post_level", 32'(wbuf_level), 32'd0);
    chk("t6_post_empty", 32'(wbuf_empty), 32'd1);
    chk("t6_post_log", 32'(log_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
